// File: rtl/zlib_seq.sv
// Job sequencer for the fixed-Huffman zlib engine: starts engine and Adler-32,
// gates LZ77 tokens into the engine during its data phase and reports completion.
module zlib_seq #(
    parameter int unsigned LIT_DAT_WD = 8,
    parameter int unsigned LEN_DAT_WD = 7,
    parameter int unsigned DIS_DAT_WD = 7,
    parameter int unsigned CNT_WD     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WD-1:0]     word_cnt_o,
    input  logic                  tok_val_i,
    output logic                  tok_rdy_o,
    input  logic                  tok_flg_lit_i,
    input  logic [LIT_DAT_WD-1:0] tok_lit_i,
    input  logic [LEN_DAT_WD-1:0] tok_len_i,
    input  logic [DIS_DAT_WD-1:0] tok_dis_i,
    input  logic                  tok_lst_i,
    output logic                  adler_start_o,
    input  logic                  adler_done_i,
    output logic                  eng_start_o,
    output logic                  eng_val_o,
    output logic                  eng_flg_lit_o,
    output logic [LIT_DAT_WD-1:0] eng_lit_o,
    output logic [LEN_DAT_WD-1:0] eng_len_o,
    output logic [DIS_DAT_WD-1:0] eng_dis_o,
    output logic                  eng_lst_o,
    input  logic                  eng_word_val_i,
    input  logic                  eng_done_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_HDR,
        ST_STREAM,
        ST_TAIL
    } state_t;

    state_t            state_r;
    logic              hdr_cnt_r;
    logic              adler_seen_r;
    logic              done_r;
    logic [CNT_WD-1:0] word_cnt_r;
    logic              in_stream;
    logic              adler_ok;
    logic              in_job;

    // Token gate: the last token waits for the checksum; zero-latency passthrough.
    always_comb begin
        in_stream     = (state_r == ST_STREAM);
        in_job        = (state_r != ST_IDLE) && (state_r != ST_START);
        adler_ok      = adler_seen_r | adler_done_i;
        tok_rdy_o     = in_stream && (!tok_lst_i || adler_ok);
        eng_val_o     = tok_val_i && tok_rdy_o;
        eng_lst_o     = tok_lst_i && eng_val_o;
        eng_flg_lit_o = in_stream && tok_flg_lit_i;
        eng_lit_o     = in_stream ? tok_lit_i : '0;
        eng_len_o     = in_stream ? tok_len_i : '0;
        eng_dis_o     = in_stream ? tok_dis_i : '0;
    end

    assign busy_o        = (state_r != ST_IDLE);
    assign eng_start_o   = (state_r == ST_START);
    assign adler_start_o = (state_r == ST_START);
    assign done_o        = done_r;
    assign word_cnt_o    = word_cnt_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            hdr_cnt_r    <= 1'b0;
            adler_seen_r <= 1'b0;
            done_r       <= 1'b0;
            word_cnt_r   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_i) state_r <= ST_START;
                end
                ST_START: begin
                    word_cnt_r   <= '0;
                    adler_seen_r <= 1'b0;
                    hdr_cnt_r    <= 1'b0;
                    state_r      <= ST_HDR;
                end
                // Two cycles for the engine's zlib header and block header.
                ST_HDR: begin
                    hdr_cnt_r <= 1'b1;
                    if (hdr_cnt_r) state_r <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (eng_val_o && tok_lst_i) state_r <= ST_TAIL;
                end
                ST_TAIL: begin
                    if (eng_done_i) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b1;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase

            // Checksum flag and saturating word count are live from HDR onwards.
            if (in_job) begin
                if (adler_done_i) adler_seen_r <= 1'b1;
                if (eng_word_val_i && (word_cnt_r != {CNT_WD{1'b1}}))
                    word_cnt_r <= word_cnt_r + CNT_WD'(1);
            end
        end
    end

endmodule

// File: tb/tb_zlib_seq.sv
// Self-checking bench for zlib_seq: scheduled jobs and random jobs checked against
// acceptance cycles derived arithmetically from the job timing rules.
module tb_zlib_seq;

    localparam int unsigned LIT_W = 8;
    localparam int unsigned LEN_W = 7;
    localparam int unsigned DIS_W = 7;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] word_cnt_o;
    logic             tok_val_i;
    logic             tok_rdy_o;
    logic             tok_flg_lit_i;
    logic [LIT_W-1:0] tok_lit_i;
    logic [LEN_W-1:0] tok_len_i;
    logic [DIS_W-1:0] tok_dis_i;
    logic             tok_lst_i;
    logic             adler_start_o;
    logic             adler_done_i;
    logic             eng_start_o;
    logic             eng_val_o;
    logic             eng_flg_lit_o;
    logic [LIT_W-1:0] eng_lit_o;
    logic [LEN_W-1:0] eng_len_o;
    logic [DIS_W-1:0] eng_dis_o;
    logic             eng_lst_o;
    logic             eng_word_val_i;
    logic             eng_done_i;

    always #5 clk = ~clk;

    zlib_seq #(
        .LIT_DAT_WD(LIT_W),
        .LEN_DAT_WD(LEN_W),
        .DIS_DAT_WD(DIS_W),
        .CNT_WD    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .word_cnt_o    (word_cnt_o),
        .tok_val_i     (tok_val_i),
        .tok_rdy_o     (tok_rdy_o),
        .tok_flg_lit_i (tok_flg_lit_i),
        .tok_lit_i     (tok_lit_i),
        .tok_len_i     (tok_len_i),
        .tok_dis_i     (tok_dis_i),
        .tok_lst_i     (tok_lst_i),
        .adler_start_o (adler_start_o),
        .adler_done_i  (adler_done_i),
        .eng_start_o   (eng_start_o),
        .eng_val_o     (eng_val_o),
        .eng_flg_lit_o (eng_flg_lit_o),
        .eng_lit_o     (eng_lit_o),
        .eng_len_o     (eng_len_o),
        .eng_dis_o     (eng_dis_o),
        .eng_lst_o     (eng_lst_o),
        .eng_word_val_i(eng_word_val_i),
        .eng_done_i    (eng_done_i)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit pending_done = 1'b0;
    int last_words = 0;

    logic             t_flg [16];
    logic [LIT_W-1:0] t_lit [16];
    logic [LEN_W-1:0] t_len [16];
    logic [DIS_W-1:0] t_dis [16];

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            t_flg[i] = 1'($urandom);
            t_lit[i] = LIT_W'($urandom);
            t_len[i] = LEN_W'($urandom);
            t_dis[i] = DIS_W'($urandom);
        end
    endtask

    task automatic drive_quiet();
        start_i        = 1'b0;
        tok_val_i      = 1'b0;
        tok_flg_lit_i  = 1'b0;
        tok_lit_i      = '0;
        tok_len_i      = '0;
        tok_dis_i      = '0;
        tok_lst_i      = 1'b0;
        adler_done_i   = 1'b0;
        eng_word_val_i = 1'b0;
        eng_done_i     = 1'b0;
    endtask

    // One IDLE cycle with a pending last token on the bus; nothing may be accepted.
    task automatic idle_cycle();
        logic [6:0] exp_ctrl;
        logic [6:0] act_ctrl;
        drive_quiet();
        tok_val_i = 1'b1;
        tok_lst_i = 1'b1;
        tok_lit_i = LIT_W'($urandom);
        #3;
        exp_ctrl = {4'b0000, pending_done, 2'b00};
        act_ctrl = {eng_start_o, adler_start_o, busy_o, tok_rdy_o, done_o, eng_val_o, eng_lst_o};
        n_chk++;
        if (act_ctrl !== exp_ctrl) begin
            n_fail++;
            $display("FAIL idle_ctrl: got %b expected %b", act_ctrl, exp_ctrl);
        end
        n_chk++;
        if (word_cnt_o !== CNT_W'(last_words)) begin
            n_fail++;
            $display("FAIL idle_word_cnt: got %0d expected %0d", word_cnt_o, last_words);
        end
        pending_done = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Runs one job from its start cycle (c=0) up to, but excluding, its done_o cycle.
    // Tokens t_*[0..n-1] are presented back-to-back from cycle p0; the engine model
    // emits nw words after the last token, raising eng_done_i on the final one.
    task automatic run_job(input int n, input int p0, input int adler_cyc, input int nw,
                           input bit pre_adler, input bit stray);
        int acc [16];
        int first, base, lst_cyc, dcyc, idx;
        bit exp_rdy, exp_val;
        logic [6:0] exp_ctrl;
        logic [6:0] act_ctrl;
        first = (p0 > 4) ? p0 : 4;
        for (int i = 0; i < n - 1; i++) acc[i] = first + i;
        base    = first + n - 1;
        lst_cyc = (adler_cyc > base) ? adler_cyc : base;
        acc[n-1] = lst_cyc;
        dcyc    = lst_cyc + nw + 1;
        for (int c = 0; c < dcyc; c++) begin
            idx = 0;
            for (int i = 0; i < n; i++) if (acc[i] < c) idx++;
            drive_quiet();
            start_i   = (c == 0) || (stray && (c == 5 || c == lst_cyc + 1));
            tok_val_i = (c >= p0) && (idx < n);
            if (idx < n) begin
                tok_flg_lit_i = t_flg[idx];
                tok_lit_i     = t_lit[idx];
                tok_len_i     = t_len[idx];
                tok_dis_i     = t_dis[idx];
            end
            tok_lst_i      = tok_val_i && (idx == n - 1);
            adler_done_i   = (c == adler_cyc) || (pre_adler && c == 0);
            eng_word_val_i = (c > lst_cyc) && (c <= lst_cyc + nw);
            eng_done_i     = (c == lst_cyc + nw);
            #3;
            exp_val  = (idx < n) && (acc[idx] == c);
            exp_rdy  = (c >= 4) && (c <= lst_cyc) && !(tok_lst_i && c < lst_cyc);
            exp_ctrl = {c == 1, c == 1, c >= 1, exp_rdy, (c == 0) && pending_done,
                        exp_val, exp_val && (c == lst_cyc)};
            act_ctrl = {eng_start_o, adler_start_o, busy_o, tok_rdy_o, done_o, eng_val_o, eng_lst_o};
            n_chk++;
            if (act_ctrl !== exp_ctrl) begin
                n_fail++;
                $display("FAIL job_ctrl cycle %0d: got %b expected %b (start,astart,busy,rdy,done,val,lst)",
                         c, act_ctrl, exp_ctrl);
            end
            if (exp_val) begin
                n_chk++;
                if ({eng_flg_lit_o, eng_lit_o, eng_len_o, eng_dis_o} !==
                    {t_flg[idx], t_lit[idx], t_len[idx], t_dis[idx]}) begin
                    n_fail++;
                    $display("FAIL tok_fields cycle %0d tok %0d: got %h expected %h", c, idx,
                             {eng_flg_lit_o, eng_lit_o, eng_len_o, eng_dis_o},
                             {t_flg[idx], t_lit[idx], t_len[idx], t_dis[idx]});
                end
            end
            if (c == 0 && pending_done) begin
                n_chk++;
                if (word_cnt_o !== CNT_W'(last_words)) begin
                    n_fail++;
                    $display("FAIL done_word_cnt: got %0d expected %0d", word_cnt_o, last_words);
                end
            end
            if (c == 2) begin
                n_chk++;
                if (word_cnt_o !== '0) begin
                    n_fail++;
                    $display("FAIL cleared_word_cnt: got %0d expected 0", word_cnt_o);
                end
            end
            @(posedge clk);
            #1;
        end
        pending_done = 1'b1;
        last_words   = nw;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_quiet();
        #1;
        n_chk++;
        if ({busy_o, done_o, word_cnt_o, tok_rdy_o, eng_val_o, eng_lst_o, eng_start_o, adler_start_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b cnt=%0d rdy=%b val=%b expected all 0",
                     busy_o, done_o, word_cnt_o, tok_rdy_o, eng_val_o);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycle();
    endtask

    task automatic test_basic();
        for (int i = 0; i < 5; i++) begin
            t_flg[i] = 1'b1;
            t_lit[i] = LIT_W'(8'h41 + i);
            t_len[i] = '0;
            t_dis[i] = '0;
        end
        run_job(5, 4, 3, 3, 1'b0, 1'b0);
        idle_cycle();
    endtask

    task automatic test_late_adler();
        fill_random(3);
        run_job(3, 4, 20, 2, 1'b0, 1'b0);
        idle_cycle();
        fill_random(3);
        run_job(3, 4, 21, 2, 1'b0, 1'b0);
        idle_cycle();
    endtask

    task automatic test_early_tokens();
        fill_random(4);
        run_job(4, 0, 3, 2, 1'b0, 1'b0);
        idle_cycle();
    endtask

    task automatic test_single_token();
        t_flg[0] = 1'b0;
        t_lit[0] = '0;
        t_len[0] = LEN_W'(3);
        t_dis[0] = DIS_W'(1);
        run_job(1, 4, 2, 2, 1'b0, 1'b0);
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_ignored_start();
        fill_random(2);
        run_job(2, 4, 12, 3, 1'b1, 1'b1);
        idle_cycle();
    endtask

    task automatic test_reset_mid_stream();
        fill_random(12);
        for (int c = 0; c <= 10; c++) begin
            drive_quiet();
            start_i        = (c == 0);
            tok_val_i      = (c >= 4);
            tok_flg_lit_i  = 1'b1;
            tok_lit_i      = t_lit[(c > 4) ? c - 4 : 0] | LIT_W'(1);
            tok_len_i      = t_len[(c > 4) ? c - 4 : 0] | LEN_W'(1);
            tok_dis_i      = t_dis[(c > 4) ? c - 4 : 0] | DIS_W'(1);
            eng_word_val_i = (c >= 4) && (c <= 9);
            #3;
            if (c == 10) begin
                n_chk++;
                if (word_cnt_o !== CNT_W'(6)) begin
                    n_fail++;
                    $display("FAIL pre_reset_word_cnt: got %0d expected 6", word_cnt_o);
                end
                rst = 1'b1;
                #1;
                n_chk++;
                if ({busy_o, done_o, word_cnt_o, tok_rdy_o, eng_val_o, eng_lst_o, eng_start_o,
                     adler_start_o, eng_flg_lit_o, eng_lit_o, eng_len_o, eng_dis_o} !== '0) begin
                    n_fail++;
                    $display("FAIL async_reset_outputs: got busy=%b cnt=%0d rdy=%b val=%b lit=%h expected all 0",
                             busy_o, word_cnt_o, tok_rdy_o, eng_val_o, eng_lit_o);
                end
            end
            @(posedge clk);
            #1;
        end
        n_chk++;
        if (done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %b expected 0", done_o);
        end
        rst          = 1'b0;
        pending_done = 1'b0;
        last_words   = 0;
        idle_cycle();
        fill_random(3);
        run_job(3, 4, 5, 4, 1'b0, 1'b0);
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        fill_random(2);
        run_job(2, 4, 2, 1, 1'b0, 1'b0);
        fill_random(3);
        run_job(3, 5, 9, 2, 1'b0, 1'b0);
        idle_cycle();
    endtask

    task automatic test_random();
        int n;
        for (int j = 0; j < 25; j++) begin
            n = $urandom_range(1, 8);
            fill_random(n);
            run_job(n, $urandom_range(0, 7), $urandom_range(2, 16), $urandom_range(1, 5),
                    1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_late_adler();
        test_early_tokens();
        test_single_token();
        test_ignored_start();
        test_reset_mid_stream();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
